// File: rtl/ext_access_ctrl.sv
// External-data access sequencer: stalls the front of the pipeline while a req/ack read completes.
// Optional REQ timeout with sticky error flag is built when EXT_TIMEOUT_EN is defined.
module ext_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_ext_rd,
    input  logic [7:0]  ex_addr,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic        ext_req,
    output logic [7:0]  ext_addr,
    output logic        stall,
    output logic        wb_kill,
    output logic [7:0]  ext_data,
    output logic        ext_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ext_access_ctrl: TIMEOUT must be in 2..255");
    end

    state_t      state_q, state_d;
    logic        ext_req_q, ext_req_d;
    logic [7:0]  ext_addr_q, ext_addr_d;
    logic [7:0]  ext_data_q, ext_data_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        trigger;

`ifdef EXT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       ext_err_q, ext_err_d;
`endif

    // DONE deliberately ignores the trigger so the released load gets its writeback slot.
    assign trigger = (state_q == IDLE) && ex_valid && ex_ext_rd;
    assign stall   = trigger || (state_q == REQ);
    assign wb_kill = stall;

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_addr_d  = ext_addr_q;
        ext_data_d  = ext_data_q;
        stall_cnt_d = stall_cnt_q;
`ifdef EXT_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        ext_err_d   = ext_err_q;
`endif

        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    ext_addr_d = ex_addr;
                    ext_req_d  = 1'b1;
                    state_d    = REQ;
`ifdef EXT_TIMEOUT_EN
                    tmo_cnt_d  = 8'd0;
`endif
                end
            end
            REQ: begin
                // Ack has priority over an expiring timeout.
                if (ext_ack) begin
                    ext_data_d = ext_rdata;
                    ext_req_d  = 1'b0;
                    state_d    = DONE;
                end
`ifdef EXT_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    ext_data_d = 8'h00;
                    ext_req_d  = 1'b0;
                    ext_err_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ext_req_q   <= 1'b0;
            ext_addr_q  <= 8'h00;
            ext_data_q  <= 8'h00;
            stall_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_addr_q  <= ext_addr_d;
            ext_data_q  <= ext_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef EXT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 8'd0;
            ext_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            ext_err_q <= ext_err_d;
        end
    end

    assign ext_err = ext_err_q;
`else
    assign ext_err = 1'b0;
`endif

    assign ext_req   = ext_req_q;
    assign ext_addr  = ext_addr_q;
    assign ext_data  = ext_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
